// File: rtl/div_seq_pkg.sv
// Shared types and constants for the multicycle divider control stage.
package div_seq_pkg;

    localparam int DIV_W              = 32;
    localparam int CNT_W              = 4;
    localparam int SETTLE_CYCLES_DFLT = 4;
    // Lane 0 carries dividend/quotient, lane 1 carries divisor/remainder.
    localparam int NUM_LANES          = 2;

    localparam logic [DIV_W-1:0] ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Per-lane sign handling: operand magnitude on the way in, result negation on the way out.
module div_sign_fix
    import div_seq_pkg::*;
(
    input  logic [DIV_W-1:0] opnd,
    input  logic             is_signed,
    output logic [DIV_W-1:0] mag,
    output logic             opnd_neg,
    input  logic [DIV_W-1:0] res,
    input  logic             res_neg,
    output logic [DIV_W-1:0] res_fix
);

    always_comb begin
        opnd_neg = is_signed & opnd[DIV_W-1];
        // -0x8000_0000 wraps to itself, which is the correct unsigned magnitude.
        mag      = opnd_neg ? -opnd : opnd;
        res_fix  = res_neg ? -res : res;
    end

endmodule

// File: rtl/div_sequencer.sv
// Holds operands stable on an external combinational divider for SETTLE_CYCLES,
// captures {rem, quot}, applies sign correction and hands off over valid/ready.
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DFLT
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               is_signed,
    input  logic [DIV_W-1:0]   a,
    input  logic [DIV_W-1:0]   b,
    output logic               in_ready,
    output logic [DIV_W-1:0]   div_a,
    output logic [DIV_W-1:0]   div_b,
    input  logic [2*DIV_W-1:0] div_result,
    output logic [DIV_W-1:0]   hi,
    output logic [DIV_W-1:0]   lo,
    output logic               div_by_zero,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             zero_q, zero_d;
    logic [DIV_W-1:0] a_raw_q, a_raw_d;
    logic [DIV_W-1:0] div_a_q, div_a_d;
    logic [DIV_W-1:0] div_b_q, div_b_d;
    logic [DIV_W-1:0] raw_quot_q, raw_quot_d;
    logic [DIV_W-1:0] raw_rem_q, raw_rem_d;
    logic [DIV_W-1:0] hi_q, hi_d;
    logic [DIV_W-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;

    logic [NUM_LANES-1:0][DIV_W-1:0] opnd, mag, res, res_fix;
    logic [NUM_LANES-1:0]            opnd_neg, res_neg;

    assign opnd    = {b, a};
    assign res     = {raw_rem_q, raw_quot_q};
    assign res_neg = {a_neg_q, a_neg_q ^ b_neg_q};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        div_sign_fix u_fix (
            .opnd     (opnd[l]),
            .is_signed(is_signed),
            .mag      (mag[l]),
            .opnd_neg (opnd_neg[l]),
            .res      (res[l]),
            .res_neg  (res_neg[l]),
            .res_fix  (res_fix[l])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        zero_d      = zero_q;
        a_raw_d     = a_raw_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        raw_quot_d  = raw_quot_q;
        raw_rem_d   = raw_rem_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_neg_d = opnd_neg[0];
                    b_neg_d = opnd_neg[1];
                    a_raw_d = a;
                    div_a_d = mag[0];
                    div_b_d = mag[1];
                    zero_d  = (b == '0);
                    if (b == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    raw_quot_d = div_result[DIV_W-1:0];
                    raw_rem_d  = div_result[2*DIV_W-1:DIV_W];
                    state_d    = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                if (zero_q) begin
                    lo_d = ZERO_QUOT;
                    hi_d = a_raw_q;
                end else begin
                    lo_d = res_fix[0];
                    hi_d = res_fix[1];
                end
                dbz_d       = zero_q;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            zero_q      <= 1'b0;
            a_raw_q     <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            raw_quot_q  <= '0;
            raw_rem_q   <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            zero_q      <= zero_d;
            a_raw_q     <= a_raw_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            raw_quot_q  <= raw_quot_d;
            raw_rem_q   <= raw_rem_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural divider and a result scoreboard.
module tb_div_sequencer;

    logic        clock, clear, start, is_signed, out_ready;
    logic [31:0] a, b;
    logic        in_ready, div_by_zero, out_valid;
    logic [31:0] div_a, div_b, hi, lo;
    logic [63:0] div_result;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    div_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .is_signed  (is_signed),
        .a          (a),
        .b          (b),
        .in_ready   (in_ready),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Stand-in for the external combinational divider.
    always_comb begin
        if (div_b == 32'd0) div_result = 64'd0;
        else                div_result = {div_a % div_b, div_a / div_b};
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic sg);
        exp_t               e;
        logic signed [31:0] sq, sr;
        if (bv == 32'd0) begin
            e.lo = 32'hFFFF_FFFF; e.hi = av; e.dbz = 1'b1;
        end else if (sg) begin
            sq = $signed(av) / $signed(bv);
            sr = $signed(av) % $signed(bv);
            e.lo = sq; e.hi = sr; e.dbz = 1'b0;
        end else begin
            e.lo = av / bv; e.hi = av % bv; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: a result is consumed on the cycle out_valid and out_ready are both high.
    always @(negedge clock) begin : mon
        exp_t e;
        if (!clear && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("lo", lo, e.lo);
                chk("hi", hi, e.hi);
                chk("div_by_zero", div_by_zero, e.dbz);
            end
        end
    end

    // Issues one request from IDLE and measures edges from E0 until out_valid.
    task automatic do_req(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic edbz,
                          input int elat);
        exp_t e;
        int   lat;
        e.lo = elo; e.hi = ehi; e.dbz = edbz;
        a = av; b = bv; is_signed = sg; start = 1'b1;
        sb.push_back(e);
        @(posedge clock); #1;
        start = 1'b0;
        chk("in_ready_busy", in_ready, 1'b0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(elat));
        if (out_ready) begin
            @(posedge clock); #1;
            chk("valid_one_cycle", out_valid, 1'b0);
            chk("in_ready_back", in_ready, 1'b1);
        end
    endtask

    initial begin
        exp_t e;
        logic [31:0] ra, rb;
        logic        rs;

        clear = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dbz", div_by_zero, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);

        do_req(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 5);

        do_req(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 5);
        chk("signed_div_a", div_a, 32'd7);
        chk("signed_div_b", div_b, 32'd2);

        do_req(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);

        // Backpressure with an ignored second start.
        out_ready = 1'b0;
        do_req(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 5);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin a = 32'd1; b = 32'd1; start = 1'b1; end
            else start = 1'b0;
            @(posedge clock); #1;
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_lo", lo, 32'd100);
            chk("bp_hi", hi, 32'd0);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        start = 1'b0;
        chk("bp_div_a_held", div_a, 32'd1000);
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_release_idle", in_ready, 1'b1);
        chk("bp_release_valid", out_valid, 1'b0);

        // Clear two edges into WAIT discards the request.
        a = 32'd50; b = 32'd5; is_signed = 1'b0; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (2) @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock); #1 clear = 1'b0;
        chk("clr_in_ready", in_ready, 1'b1);
        chk("clr_out_valid", out_valid, 1'b0);
        chk("clr_hi", hi, 32'd0);
        chk("clr_lo", lo, 32'd0);
        repeat (8) @(posedge clock);
        #1 chk("clr_no_result", out_valid, 1'b0);
        do_req(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 5);

        do_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 5);
        do_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 5);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom_range(1, 32'h7FFF) ^ ((i % 2 == 1) ? 32'hFFFF_0000 : 32'd0);
            rs = (i % 3) != 0;
            if (rb == 32'hFFFF_FFFF) rb = 32'd3;
            e = model(ra, rb, rs);
            do_req(ra, rb, rs, e.lo, e.hi, e.dbz, (rb == 32'd0) ? 1 : 5);
        end

        repeat (2) @(posedge clock);
        #1 chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle control stage wrapped around the combinational 32-bit unsigned divider. It accepts signed or unsigned DIV requests from the datapath control unit and registers the operand magnitudes onto the divider inputs. It holds those inputs stable for a fixed number of settle cycles, then captures the divider's 64-bit {remainder, quotient}. It applies sign correction and delivers the result to the HI/LO register pair over a valid/ready handshake. The deep divider therefore runs as a declared multicycle path instead of limiting the clock.

## Interface
- SETTLE_CYCLES, 4: number of cycles the divider inputs are held before capture; legal range 1..15.
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request strobe; accepted only when in_ready=1.
- is_signed  in  1  1 = two's-complement division, 0 = unsigned; sampled with start.
- a  in  32  dividend; sampled with start.
- b  in  32  divisor; sampled with start.
- in_ready  out  1  high only in IDLE.
- div_a  out  32  registered dividend magnitude, to the divider.
- div_b  out  32  registered divisor magnitude, to the divider.
- div_result  in  64  divider output; [63:32]=remainder, [31:0]=quotient.
- hi  out  32  final remainder.
- lo  out  32  final quotient.
- div_by_zero  out  1  set when the delivered result came from b==0.
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  consumer accepts the result.

## Operation
- States: IDLE, WAIT, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On start at edge E0, register a_neg = is_signed & a[31], b_neg = is_signed & b[31], and the raw a.
  - div_a = |a| if is_signed, else a. div_b follows the same rule for b.
  - If b==0, go to FIX with the zero flag set. Otherwise load cnt=SETTLE_CYCLES-1 and go to WAIT.
- WAIT:
  - div_a and div_b are held constant.
  - Each edge decrements cnt.
  - On the edge where cnt==0, capture div_result into raw_q/raw_r and go to FIX.
- FIX (one edge):
  - lo = (a_neg^b_neg) ? -raw_q : raw_q.
  - hi = a_neg ? -raw_r : raw_r. The remainder takes the dividend's sign; quotient truncates toward zero.
  - Zero divisor: lo=32'hFFFF_FFFF, hi=raw a, div_by_zero=1.
  - Set out_valid and go to DONE.
- DONE:
  - hi, lo, div_by_zero and out_valid hold.
  - On an edge with out_ready=1, clear out_valid and go to IDLE. hi and lo keep their last values.
- start outside IDLE is ignored; there is no queueing.
- |0x8000_0000| = 0x8000_0000 as unsigned. Signed 0x8000_0000 / 0xFFFF_FFFF yields lo=0x8000_0000, hi=0. No overflow flag is produced.
- All arithmetic is 32-bit modulo 2^32.

## Timing
- Reset values (clear=1 at an edge): state=IDLE, in_ready=1, out_valid=0, div_by_zero=0, hi=lo=0, div_a=div_b=0, cnt=0.
- clear takes priority over every other event at the same edge, including mid-WAIT and in DONE. Any in-flight result is discarded.
- Normal latency: out_valid goes high after edge E0+SETTLE_CYCLES+1. With the default, that is 5 edges after E0.
- Divide-by-zero latency: out_valid goes high after edge E0+1.
- in_ready is low from E0 until the DONE→IDLE edge. The next start can be accepted at the edge after that one.
- If out_ready is already 1 when DONE is entered, the handshake completes on the first DONE edge, so out_valid is high for exactly one cycle.

## Structure
- Package div_seq_pkg:
  - state enum (IDLE, WAIT, FIX, DONE);
  - DIV_W=32;
  - default SETTLE_CYCLES;
  - ZERO_QUOT=32'hFFFF_FFFF.
- Sub-module div_sign_fix, combinational:
  - magnitude of one operand given the is_signed flag;
  - quotient/remainder negation from a_neg and b_neg.
  - Instantiated for both the input path and the FIX path.
- The divider itself is instantiated outside this block. The path div_a/div_b → div_result is constrained as a SETTLE_CYCLES multicycle path.

## Test plan
- Unsigned a=100, b=7, out_ready=1 → lo=14, hi=2, div_by_zero=0; out_valid high exactly 5 edges after E0 for one cycle.
- Signed a=0xFFFF_FFF9 (-7), b=2 → div_a=7, div_b=2; lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
- a=5, b=0 → lo=0xFFFF_FFFF, hi=5, div_by_zero=1, out_valid after E0+1.
- Backpressure: out_ready=0 for 10 cycles after out_valid. hi, lo and out_valid hold, and a second start is ignored (in_ready=0). Raising out_ready returns the block to IDLE at the next edge.
- clear asserted two edges into WAIT → next cycle state=IDLE, out_valid=0, hi=lo=0, in_ready=1. A new request of 9/3 then returns lo=3, hi=0.
- Signed 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0. Unsigned 0x8000_0000 / 0xFFFF_FFFF → lo=0, hi=0x8000_0000.
